// File: rtl/codec_pkg.sv
// codec_pkg: shared types and defaults for the codec stream scheduler
package codec_pkg;
  localparam int W_DEF = 16;
  typedef enum logic [1:0] {SRC0, SRC1, RR, MIX} mode_t;
  typedef enum logic {SETTLE, RUN} sched_state_t;
endpackage

// File: rtl/codec_stream_sched_if.sv
// codec_stream_sched_if: codec, source and rx stream signals of the scheduler
interface codec_stream_sched_if import codec_pkg::*; #(parameter int W = W_DEF);
  logic         codec_vld;
  logic [W-1:0] codec_lft_in, codec_rht_in, codec_lft_out, codec_rht_out;
  logic [1:0]   mode, src_vld, src_rdy;
  logic [W-1:0] src0_lft, src0_rht, src1_lft, src1_rht;
  logic         rx_vld, muted, underrun;
  logic [W-1:0] rx_lft, rx_rht;
  logic [15:0]  frame_cnt;
  modport slave (
    input  codec_vld, codec_lft_in, codec_rht_in, mode, src_vld,
           src0_lft, src0_rht, src1_lft, src1_rht,
    output codec_lft_out, codec_rht_out, src_rdy, rx_vld, rx_lft, rx_rht,
           muted, underrun, frame_cnt
  );
  modport master (
    output codec_vld, codec_lft_in, codec_rht_in, mode, src_vld,
           src0_lft, src0_rht, src1_lft, src1_rht,
    input  codec_lft_out, codec_rht_out, src_rdy, rx_vld, rx_lft, rx_rht,
           muted, underrun, frame_cnt
  );
endinterface

// File: rtl/codec_src_holder.sv
// codec_src_holder: one-deep sample-pair holding register; pushes while full are dropped
module codec_src_holder import codec_pkg::*; #(parameter int W = W_DEF) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_vld,
  input  logic         i_pop,
  input  logic [W-1:0] i_lft,
  input  logic [W-1:0] i_rht,
  output logic         o_full,
  output logic [W-1:0] o_lft,
  output logic [W-1:0] o_rht
);
  logic         r_full;
  logic [W-1:0] r_lft, r_rht;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
      r_lft  <= '0;
      r_rht  <= '0;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end else if (i_vld && !r_full) begin
      r_full <= 1'b1;
      r_lft  <= i_lft;
      r_rht  <= i_rht;
    end
  end
  assign o_full = r_full;
  assign o_lft  = r_lft;
  assign o_rht  = r_rht;
endmodule

// File: rtl/codec_stream_sched.sv
// codec_stream_sched: settles after reset, then serves one source pair per codec frame
module codec_stream_sched import codec_pkg::*; #(
  parameter int W             = W_DEF,
  parameter int SETTLE_FRAMES = 4,
  parameter int HOLD_LAST     = 1
) (
  input logic clk,
  input logic rst,
  codec_stream_sched_if.slave bus
);
  sched_state_t r_state, w_state_nxt;
  mode_t        w_mode;
  logic         r_vld_q, r_ptr, r_ur, r_rx_vld;
  logic [15:0]  r_settle, r_cnt;
  logic [W-1:0] r_l, r_r, r_rxl, r_rxr, w_nl, w_nr;
  logic [W-1:0] w_lft [2];
  logic [W-1:0] w_rht [2];
  logic [W:0]   w_sl, w_sr;
  logic [1:0]   w_full, w_pop, w_rr;
  logic         w_strb, w_run_strb, w_ur;
  codec_src_holder #(.W(W)) u_h0 (
    .clk(clk), .rst(rst), .i_vld(bus.src_vld[0]), .i_pop(w_pop[0]),
    .i_lft(bus.src0_lft), .i_rht(bus.src0_rht),
    .o_full(w_full[0]), .o_lft(w_lft[0]), .o_rht(w_rht[0])
  );
  codec_src_holder #(.W(W)) u_h1 (
    .clk(clk), .rst(rst), .i_vld(bus.src_vld[1]), .i_pop(w_pop[1]),
    .i_lft(bus.src1_lft), .i_rht(bus.src1_rht),
    .o_full(w_full[1]), .o_lft(w_lft[1]), .o_rht(w_rht[1])
  );
  assign w_mode     = mode_t'(bus.mode);
  assign w_strb     = bus.codec_vld & ~r_vld_q;
  assign w_run_strb = w_strb & (r_state == RUN);
  always_ff @(posedge clk) r_state <= rst ? SETTLE : w_state_nxt;
  always_comb begin
    w_state_nxt = (r_state == SETTLE && w_strb && r_settle == 16'(SETTLE_FRAMES - 1)) ? RUN : r_state;
  end
  // one extra bit keeps the mix sum exact before the halving shift
  always_comb begin
    w_rr  = r_ptr ? (w_full[1] ? 2'b10 : {1'b0, w_full[0]}) : (w_full[0] ? 2'b01 : {w_full[1], 1'b0});
    w_pop = !w_run_strb ? 2'b00 : w_mode == SRC0 ? {1'b0, w_full[0]} :
            w_mode == SRC1 ? {w_full[1], 1'b0} : w_mode == RR ? w_rr : {2{&w_full}};
    w_ur  = w_run_strb & ~|w_pop;
    w_sl  = {w_lft[0][W-1], w_lft[0]} + {w_lft[1][W-1], w_lft[1]};
    w_sr  = {w_rht[0][W-1], w_rht[0]} + {w_rht[1][W-1], w_rht[1]};
    w_nl  = w_mode == MIX ? w_sl[W:1] : w_pop[1] ? w_lft[1] : w_lft[0];
    w_nr  = w_mode == MIX ? w_sr[W:1] : w_pop[1] ? w_rht[1] : w_rht[0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_q  <= 1'b0;
      r_settle <= '0;
      r_ptr    <= 1'b0;
      r_ur     <= 1'b0;
      r_rx_vld <= 1'b0;
      r_cnt    <= '0;
      r_l      <= '0;
      r_r      <= '0;
      r_rxl    <= '0;
      r_rxr    <= '0;
    end else begin
      r_vld_q  <= bus.codec_vld;
      r_ur     <= w_ur;
      r_rx_vld <= w_run_strb;
      if (r_state == SETTLE && w_strb) r_settle <= r_settle + 16'd1;
      if (|w_pop) begin
        r_l <= w_nl;
        r_r <= w_nr;
      end else if (w_ur && HOLD_LAST == 0) begin
        r_l <= '0;
        r_r <= '0;
      end
      if (w_mode == RR && |w_pop) r_ptr <= w_pop[0];
      if (w_run_strb) begin
        r_cnt <= r_cnt + 16'd1;
        r_rxl <= bus.codec_lft_in;
        r_rxr <= bus.codec_rht_in;
      end
    end
  end
  assign bus.codec_lft_out = r_l;
  assign bus.codec_rht_out = r_r;
  assign bus.src_rdy       = ~w_full;
  assign bus.rx_vld        = r_rx_vld;
  assign bus.rx_lft        = r_rxl;
  assign bus.rx_rht        = r_rxr;
  assign bus.muted         = r_state == SETTLE;
  assign bus.underrun      = r_ur;
  assign bus.frame_cnt     = r_cnt;
endmodule

// File: tb/tb_codec_stream_sched.sv
// tb_codec_stream_sched: frame-level reference model against zero-fill and hold-last instances
module tb_codec_stream_sched;
  logic clk = 1'b0, rst = 1'b1, codec_vld = 1'b0;
  logic [15:0] cl_in = '0, cr_in = '0, s0l = '0, s0r = '0, s1l = '0, s1r = '0;
  logic [1:0] mode = '0, src_vld = '0;
  int n_cmp = 0, n_bad = 0, n_ur = 0, n_rxv = 0, c0, u0, x0;
  bit chk_en = 0;
  always #5 clk = ~clk;

  codec_stream_sched_if b0 ();
  codec_stream_sched_if b1 ();
  assign {b0.codec_vld, b1.codec_vld} = {2{codec_vld}};
  assign {b0.codec_lft_in, b1.codec_lft_in} = {2{cl_in}};
  assign {b0.codec_rht_in, b1.codec_rht_in} = {2{cr_in}};
  assign {b0.mode, b1.mode} = {2{mode}};
  assign {b0.src_vld, b1.src_vld} = {2{src_vld}};
  assign {b0.src0_lft, b1.src0_lft} = {2{s0l}};
  assign {b0.src0_rht, b1.src0_rht} = {2{s0r}};
  assign {b0.src1_lft, b1.src1_lft} = {2{s1l}};
  assign {b0.src1_rht, b1.src1_rht} = {2{s1r}};
  codec_stream_sched #(.HOLD_LAST(0)) u_zero (.clk(clk), .rst(rst), .bus(b0));
  codec_stream_sched #(.HOLD_LAST(1)) u_hold (.clk(clk), .rst(rst), .bus(b1));

  function automatic logic [15:0] mixf(input logic [15:0] a, input logic [15:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    return 16'(s >>> 1);
  endfunction

  // reference model: frame events on holders modelled as two slots
  bit m_full [2];
  logic [15:0] m_dl [2];
  logic [15:0] m_dr [2];
  logic [15:0] mh_l, mh_r, mz_l, mz_r, m_rxl, m_rxr, m_cnt;
  bit m_run, m_ptr, m_vq, m_ur, m_rxv;
  int m_settle;
  always @(posedge clk) begin
    bit strb;
    bit pf [2];
    int take;
    if (rst) begin
      m_full = '{0, 0}; m_dl = '{16'h0, 16'h0}; m_dr = '{16'h0, 16'h0};
      {mh_l, mh_r, mz_l, mz_r, m_rxl, m_rxr, m_cnt} = '0;
      {m_run, m_ptr, m_vq, m_ur, m_rxv} = '0;
      m_settle = 0;
    end else begin
      strb = codec_vld && !m_vq;
      m_vq = codec_vld;
      m_ur = 0;
      m_rxv = 0;
      pf = m_full;
      if (strb && m_run) begin
        take = -1;
        case (mode)
          2'd0: if (m_full[0]) take = 0;
          2'd1: if (m_full[1]) take = 1;
          2'd2: begin
            if (m_full[m_ptr]) take = int'(m_ptr);
            else if (m_full[!m_ptr]) take = int'(!m_ptr);
            if (take >= 0) m_ptr = (take == 0);
          end
          default: if (m_full[0] && m_full[1]) take = 2;
        endcase
        if (take == 2) begin
          mh_l = mixf(m_dl[0], m_dl[1]);
          mh_r = mixf(m_dr[0], m_dr[1]);
          m_full = '{0, 0};
        end else if (take >= 0) begin
          mh_l = m_dl[take];
          mh_r = m_dr[take];
          m_full[take] = 0;
        end else m_ur = 1;
        mz_l = m_ur ? 16'h0 : mh_l;
        mz_r = m_ur ? 16'h0 : mh_r;
        m_cnt = m_cnt + 16'd1;
        m_rxv = 1;
        m_rxl = cl_in;
        m_rxr = cr_in;
      end else if (strb) begin
        if (m_settle == 3) m_run = 1;
        else m_settle++;
      end
      if (src_vld[0] && !pf[0]) begin m_full[0] = 1; m_dl[0] = s0l; m_dr[0] = s0r; end
      if (src_vld[1] && !pf[1]) begin m_full[1] = 1; m_dl[1] = s1l; m_dr[1] = s1r; end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    n_ur  += int'(b0.underrun);
    n_rxv += int'(b0.rx_vld);
    if (chk_en) begin
      chk("hold_lft", 32'(b1.codec_lft_out), 32'(mh_l));
      chk("hold_rht", 32'(b1.codec_rht_out), 32'(mh_r));
      chk("zero_lft", 32'(b0.codec_lft_out), 32'(mz_l));
      chk("zero_rht", 32'(b0.codec_rht_out), 32'(mz_r));
      chk("src_rdy", 32'(b1.src_rdy), 32'({!m_full[1], !m_full[0]}));
      chk("muted", 32'(b1.muted), 32'(!m_run));
      chk("underrun", 32'({b1.underrun, b0.underrun}), 32'({2{m_ur}}));
      chk("rx_vld", 32'(b1.rx_vld), 32'(m_rxv));
      chk("rx_lft", 32'(b1.rx_lft), 32'(m_rxl));
      chk("rx_rht", 32'(b1.rx_rht), 32'(m_rxr));
      chk("frame_cnt", 32'({b1.frame_cnt, b0.frame_cnt}), 32'({2{m_cnt}}));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic push(input logic [1:0] v, input logic [15:0] a, b, c, d);
    {s0l, s0r, s1l, s1r} = {a, b, c, d};
    src_vld = v;
    cyc(1);
    src_vld = 2'b00;
  endtask
  task automatic frame();
    cl_in = 16'($urandom);
    cr_in = 16'($urandom);
    codec_vld = 1'b1;
    cyc(3);
    codec_vld = 1'b0;
    cyc(2);
  endtask

  initial begin
    cyc(3);
    chk_en = 1;
    chk("rst_muted", 32'(b1.muted), 32'd1);
    chk("rst_rdy", 32'(b1.src_rdy), 32'd3);
    rst = 1'b0;
    push(2'b01, 16'h1234, 16'h5678, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      frame();
      chk("settle_out", 32'(b1.codec_lft_out), 32'h0);
      chk("settle_muted", 32'(b1.muted), (i < 3) ? 32'd1 : 32'd0);
    end
    mode = 2'd0;
    frame();
    chk("first_lft", 32'(b1.codec_lft_out), 32'h1234);
    chk("first_rht", 32'(b1.codec_rht_out), 32'h5678);
    mode = 2'd2;
    u0 = n_ur;
    for (int i = 0; i < 3; i++) begin
      push(2'b11, 16'h0001, 16'h0001, 16'h0002, 16'h0002);
      frame();
      chk("rr_out", 32'(b1.codec_lft_out), (i == 1) ? 32'h2 : 32'h1);
    end
    chk("rr_no_ur", 32'(n_ur - u0), 32'd0);
    mode = 2'd1;
    frame();
    mode = 2'd3;
    push(2'b11, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    frame();
    chk("mix_max", 32'(b1.codec_lft_out), 32'h7FFF);
    push(2'b11, 16'h8000, 16'h0004, 16'hFFFF, 16'h0002);
    frame();
    chk("mix_neg", 32'(b1.codec_lft_out), 32'hBFFF);
    chk("mix_rht", 32'(b1.codec_rht_out), 32'h0003);
    push(2'b01, 16'h0100, 16'h0200, 16'h0, 16'h0);
    u0 = n_ur;
    frame();
    chk("mix_ur", 32'(n_ur - u0), 32'd1);
    chk("mix_keep", 32'(b1.src_rdy), 32'h2);
    chk("mix_hold", 32'(b1.codec_lft_out), 32'hBFFF);
    mode = 2'd0;
    frame();
    u0 = n_ur;
    frame();
    frame();
    chk("m0_ur", 32'(n_ur - u0), 32'd2);
    chk("m0_hold", 32'(b1.codec_lft_out), 32'h0100);
    chk("m0_zero", 32'(b0.codec_lft_out), 32'h0000);
    c0 = int'(b1.frame_cnt);
    x0 = n_rxv;
    cl_in = 16'hABCD;
    cr_in = 16'h1357;
    codec_vld = 1'b1;
    cyc(40);
    codec_vld = 1'b0;
    cyc(2);
    chk("long_cnt", 32'(b1.frame_cnt), 32'(c0 + 1));
    chk("long_rxv", 32'(n_rxv - x0), 32'd1);
    chk("long_rxl", 32'(b1.rx_lft), 32'hABCD);
    for (int i = 0; i < 2500; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      codec_vld = ($urandom_range(0, 2) != 0);
      mode = 2'($urandom);
      src_vld = 2'($urandom);
      {s0l, s0r, s1l, s1r} = {32'($urandom), 32'($urandom)};
      {cl_in, cr_in} = 32'($urandom);
      cyc(1);
    end
    {rst, codec_vld, src_vld} = '0;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    repeat (5) frame();
    push(2'b11, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    chk("pre_rst_rdy", 32'(b1.src_rdy), 32'h0);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("mid_rst_rdy", 32'(b1.src_rdy), 32'h3);
    chk("mid_rst_muted", 32'(b1.muted), 32'd1);
    chk("mid_rst_cnt", 32'(b1.frame_cnt), 32'h0);
    chk("mid_rst_out", 32'(b1.codec_lft_out), 32'h0);
    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
